// File: rtl/cmd_mem_arb.sv
// Round-robin arbiter that shares one command-memory read port among N_REQ cores,
// tags each read one-hot and supports per-core flush and host pause/drain.
// Optional conflict counter enabled by defining CMD_MEM_ARB_STATS_EN.
module cmd_mem_arb #(
  parameter int unsigned N_REQ                = 4,
  parameter int unsigned CMD_ADDR_WIDTH       = 8,
  parameter int unsigned CMD_WIDTH            = 128,
  parameter int unsigned CMD_MEM_READ_LATENCY = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [N_REQ-1:0]                  req,
  input  logic [N_REQ*CMD_ADDR_WIDTH-1:0]   addr,
  output logic [N_REQ-1:0]                  gnt,
  output logic [N_REQ-1:0]                  rvalid,
  output logic [CMD_WIDTH-1:0]              rdata,
  input  logic [N_REQ-1:0]                  flush,
  input  logic                              pause,
  output logic                              paused,
  output logic                              mem_en,
  output logic [CMD_ADDR_WIDTH-1:0]         mem_addr,
  input  logic [CMD_WIDTH-1:0]              mem_rdata
`ifdef CMD_MEM_ARB_STATS_EN
  ,
  output logic [15:0]                       conflict_cnt
`endif
);

  localparam int unsigned RrW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned Lat = CMD_MEM_READ_LATENCY;

  localparam logic [1:0] StRun    = 2'd0;
  localparam logic [1:0] StDrain  = 2'd1;
  localparam logic [1:0] StPaused = 2'd2;

  logic [1:0]                     state_q, state_d;
  logic [RrW-1:0]                 rr_q, rr_d;
  logic [Lat-1:0][N_REQ-1:0]      tag_q, tag_d;
  logic                           grant_ok;
  logic                           gnt_any;
  logic [RrW-1:0]                 gnt_idx;
  logic                           pipe_empty;

  // Grants are also blocked while reset is held so nothing leaks out during reset.
  assign grant_ok = (state_q == StRun) && reset;

  always_comb begin
    int unsigned idx;
    idx     = 0;
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (grant_ok) begin
      for (int unsigned off = 0; off < N_REQ; off++) begin
        idx = (32'(rr_q) + off) % N_REQ;
        if (!gnt_any && req[idx]) begin
          gnt_any  = 1'b1;
          gnt[idx] = 1'b1;
          gnt_idx  = RrW'(idx);
        end
      end
    end
  end

  assign mem_en   = gnt_any;
  assign mem_addr = gnt_any ? addr[32'(gnt_idx)*CMD_ADDR_WIDTH +: CMD_ADDR_WIDTH] : '0;
  assign rdata    = mem_rdata;

  always_comb begin
    rr_d = rr_q;
    if (gnt_any) begin
      rr_d = (gnt_idx == RrW'(N_REQ - 1)) ? '0 : gnt_idx + RrW'(1);
    end
  end

  // Flush scrubs the core's bit from every stage, including a same-cycle grant.
  always_comb begin
    tag_d    = '0;
    tag_d[0] = gnt & ~flush;
    for (int unsigned i = 1; i < Lat; i++) begin
      tag_d[i] = tag_q[i-1] & ~flush;
    end
  end

  assign rvalid     = tag_q[Lat-1] & ~flush;
  assign pipe_empty = (tag_q == '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StRun: begin
        if (pause) state_d = StDrain;
      end
      StDrain: begin
        if (!pause)          state_d = StRun;
        else if (pipe_empty) state_d = StPaused;
      end
      StPaused: begin
        if (!pause) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  assign paused = (state_q == StPaused);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StRun;
      rr_q    <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      tag_q   <= tag_d;
    end
  end

`ifdef CMD_MEM_ARB_STATS_EN
  logic [15:0] conflict_q, conflict_d;
  logic        multi_req;

  always_comb begin
    int unsigned ones;
    ones = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      ones = ones + 32'(req[i]);
    end
    multi_req = (ones >= 2);
  end

  always_comb begin
    conflict_d = conflict_q;
    if ((state_q == StRun) && multi_req && (conflict_q != 16'hFFFF)) begin
      conflict_d = conflict_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) conflict_q <= '0;
    else        conflict_q <= conflict_d;
  end

  assign conflict_cnt = conflict_q;
`endif

endmodule

// File: tb/tb_cmd_mem_arb.sv
// Directed bench for cmd_mem_arb (N_REQ=4, latency 3): a per-cycle vector table plus
// hand-written pause, reset-mid-read and (with CMD_MEM_ARB_STATS_EN) counter sequences.
module tb_cmd_mem_arb;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req;
  logic [31:0]  addr;
  logic [3:0]   gnt;
  logic [3:0]   rvalid;
  logic [127:0] rdata;
  logic [3:0]   flush;
  logic         pause;
  logic         paused;
  logic         mem_en;
  logic [7:0]   mem_addr;
  logic [127:0] mem_rdata;
`ifdef CMD_MEM_ARB_STATS_EN
  logic [15:0]  conflict_cnt;
`endif

  cmd_mem_arb #(
    .N_REQ                (4),
    .CMD_ADDR_WIDTH       (8),
    .CMD_WIDTH            (128),
    .CMD_MEM_READ_LATENCY (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .addr         (addr),
    .gnt          (gnt),
    .rvalid       (rvalid),
    .rdata        (rdata),
    .flush        (flush),
    .pause        (pause),
    .paused       (paused),
    .mem_en       (mem_en),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata)
`ifdef CMD_MEM_ARB_STATS_EN
    ,
    .conflict_cnt (conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] req;
    logic [3:0] flush;
    logic [3:0] gnt;
    logic [7:0] maddr;
    logic [3:0] rv;
  } vec_t;

  vec_t tbl[30];
  logic [3:0] rv_seq[4];
  int         rv_n;
  logic       reached;

  initial begin
    // Per-cycle table, starting right after reset release with rr=0.
    tbl[0]  = '{4'b0001, 4'b0000, 4'b0001, 8'h05, 4'b0000};
    tbl[1]  = '{4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000};
    tbl[2]  = '{4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000};
    tbl[3]  = '{4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0001};
    tbl[4]  = '{4'b1000, 4'b0000, 4'b1000, 8'h33, 4'b0000};
    tbl[5]  = '{4'b1111, 4'b0000, 4'b0001, 8'h05, 4'b0000};
    tbl[6]  = '{4'b1111, 4'b0000, 4'b0010, 8'h11, 4'b0000};
    tbl[7]  = '{4'b1111, 4'b0000, 4'b0100, 8'h22, 4'b1000};
    tbl[8]  = '{4'b1111, 4'b0000, 4'b1000, 8'h33, 4'b0001};
    tbl[9]  = '{4'b1111, 4'b0000, 4'b0001, 8'h05, 4'b0010};
    tbl[10] = '{4'b1111, 4'b0000, 4'b0010, 8'h11, 4'b0100};
    tbl[11] = '{4'b1111, 4'b0000, 4'b0100, 8'h22, 4'b1000};
    tbl[12] = '{4'b1111, 4'b0000, 4'b1000, 8'h33, 4'b0001};
    tbl[13] = '{4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0010};
    tbl[14] = '{4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0100};
    tbl[15] = '{4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b1000};
    tbl[16] = '{4'b0100, 4'b0000, 4'b0100, 8'h22, 4'b0000};
    tbl[17] = '{4'b0010, 4'b0100, 4'b0010, 8'h11, 4'b0000};
    tbl[18] = '{4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000};
    tbl[19] = '{4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000};
    tbl[20] = '{4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0010};
    tbl[21] = '{4'b0001, 4'b0001, 4'b0001, 8'h05, 4'b0000};
    tbl[22] = '{4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000};
    tbl[23] = '{4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000};
    tbl[24] = '{4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000};
    tbl[25] = '{4'b1000, 4'b0000, 4'b1000, 8'h33, 4'b0000};
    tbl[26] = '{4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000};
    tbl[27] = '{4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000};
    tbl[28] = '{4'b0000, 4'b1000, 4'b0000, 8'h00, 4'b0000};
    tbl[29] = '{4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000};

    reset     = 1'b0;
    req       = 4'b1111;
    addr      = {8'h33, 8'h22, 8'h11, 8'h05};
    flush     = '0;
    pause     = 1'b0;
    mem_rdata = '0;

    // Reset state: requests present but nothing granted.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt", 128'(gnt), 128'h0);
    chk("rst_mem_en", 128'(mem_en), 128'h0);
    chk("rst_mem_addr", 128'(mem_addr), 128'h0);
    chk("rst_rvalid", 128'(rvalid), 128'h0);
    chk("rst_paused", 128'(paused), 128'h0);
    @(negedge clk);
    reset = 1'b1;
    req   = '0;

    for (int r = 0; r < 30; r++) begin
      @(negedge clk);
      req       = tbl[r].req;
      flush     = tbl[r].flush;
      mem_rdata = {4{32'hC0DE_0000 + 32'(r)}};
      #1;
      chk($sformatf("tbl%0d_gnt", r), 128'(gnt), 128'(tbl[r].gnt));
      chk($sformatf("tbl%0d_mem_en", r), 128'(mem_en), 128'(tbl[r].gnt != 4'b0000));
      chk($sformatf("tbl%0d_mem_addr", r), 128'(mem_addr), 128'(tbl[r].maddr));
      chk($sformatf("tbl%0d_rvalid", r), 128'(rvalid), 128'(tbl[r].rv));
      if (tbl[r].rv != 4'b0000) begin
        chk($sformatf("tbl%0d_rdata", r), rdata, {4{32'hC0DE_0000 + 32'(r)}});
      end
    end

    // Pause with two reads in flight; the grant in the pause-rise cycle is still issued.
    @(negedge clk);
    req   = 4'b0001;
    flush = '0;
    #1;
    chk("pause_g0", 128'(gnt), 128'h1);
    @(negedge clk);
    req   = 4'b0010;
    pause = 1'b1;
    #1;
    chk("pause_g1_same_cycle", 128'(gnt), 128'h2);
    rv_n    = 0;
    reached = 1'b0;
    for (int i = 0; i < 12 && !reached; i++) begin
      @(negedge clk);
      req = 4'b0100;
      #1;
      chk($sformatf("drain%0d_no_gnt", i), 128'(gnt), 128'h0);
      if (rvalid != 4'b0000) begin
        if (rv_n < 4) rv_seq[rv_n] = rvalid;
        rv_n++;
        chk($sformatf("drain%0d_paused_low", i), 128'(paused), 128'h0);
      end
      if (paused) reached = 1'b1;
    end
    chk("pause_reached", 128'(reached), 128'h1);
    chk("pause_rv_count", 128'(rv_n), 128'd2);
    chk("pause_rv_first", 128'(rv_seq[0]), 128'h1);
    chk("pause_rv_second", 128'(rv_seq[1]), 128'h2);
    @(negedge clk);
    pause = 1'b0;
    #1;
    chk("unpause_still_paused_gnt", 128'(gnt), 128'h0);
    @(negedge clk);
    #1;
    chk("unpause_gnt", 128'(gnt), 128'h4);
    chk("unpause_paused", 128'(paused), 128'h0);
    @(negedge clk);
    req = '0;
    repeat (4) @(negedge clk);

    // Reset pulse one cycle after a grant; the read must vanish and rr return to 0.
    req = 4'b0001;
    #1;
    chk("rstmid_gnt", 128'(gnt), 128'h1);
    @(negedge clk);
    req   = '0;
    reset = 1'b0;
    #1;
    chk("rstmid_rvalid_in_reset", 128'(rvalid), 128'h0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rstmid%0d_no_rvalid", i), 128'(rvalid), 128'h0);
      @(negedge clk);
    end
    req = 4'b1111;
    #1;
    chk("rstmid_rr_zero", 128'(gnt), 128'h1);
    @(negedge clk);
    req = '0;
    repeat (4) @(negedge clk);

`ifdef CMD_MEM_ARB_STATS_EN
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("cnt_reset", 128'(conflict_cnt), 128'h0);
    reset = 1'b1;
    @(negedge clk);
    req = 4'b0011;
    repeat (5) @(negedge clk);
    #1;
    chk("cnt_five", 128'(conflict_cnt), 128'd5);
    repeat (65529) @(negedge clk);
    #1;
    chk("cnt_fffe", 128'(conflict_cnt), 128'hFFFE);
    repeat (3) @(negedge clk);
    #1;
    chk("cnt_saturate", 128'(conflict_cnt), 128'hFFFF);
    req = '0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cmd_mem_arb.md
CMD_MEM_ARB -- requirements
Module: cmd_mem_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4, meaning number of requesting cores (2..8).
REQ-002 SHALL have parameter CMD_ADDR_WIDTH, default 8, meaning command-memory address width.
REQ-003 SHALL have parameter CMD_WIDTH, default 128, meaning command word width.
REQ-004 SHALL have parameter CMD_MEM_READ_LATENCY, default 3, meaning cycles from mem_en to valid mem_rdata (1..8).
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1, meaning asynchronous active-low reset.
REQ-007 SHALL have port req, input, N_REQ, meaning per-core fetch request, held until granted.
REQ-008 SHALL have port addr, input, N_REQ*CMD_ADDR_WIDTH, meaning per-core instr_ptr; slice i belongs to core i.
REQ-009 SHALL have port gnt, output, N_REQ, meaning one-hot, combinational grant.
REQ-010 SHALL have port rvalid, output, N_REQ, meaning one-hot, rdata valid for core i.
REQ-011 SHALL have port rdata, output, CMD_WIDTH, meaning shared return word, equal to mem_rdata.
REQ-012 SHALL have port flush, input, N_REQ, meaning discard in-flight reads of core i.
REQ-013 SHALL have port pause, input, 1, meaning host request to stop fetches, e.g. for a command-memory write.
REQ-014 SHALL have port paused, output, 1, meaning no fetch is in flight and none will be issued.
REQ-015 SHALL have port mem_en, output, 1, meaning read strobe to command memory.
REQ-016 SHALL have port mem_addr, output, CMD_ADDR_WIDTH, meaning read address.
REQ-017 SHALL have port mem_rdata, input, CMD_WIDTH, meaning memory read data.

Function
REQ-018 SHALL implement states RUN, DRAIN and PAUSED; the reset state is RUN.
REQ-019 SHALL transition RUN->DRAIN when pause=1, DRAIN->PAUSED when the tag pipeline is empty, and PAUSED->RUN when pause=0; DRAIN with pause=0 returns to RUN.
REQ-020 SHALL, in RUN only, assert exactly one gnt bit when req!=0, chosen round-robin starting at pointer rr; gnt=0 in DRAIN and PAUSED.
REQ-021 SHALL drive mem_en=|gnt and mem_addr=addr slice of the granted core in the same cycle; when mem_en=0, mem_addr is 0.
REQ-022 SHALL, on a grant to core k, update rr to (k+1) mod N_REQ at the clock edge; rr is unchanged otherwise.
REQ-023 SHALL carry a one-hot tag through a CMD_MEM_READ_LATENCY-deep shift register and assert rvalid equal to the emerging tag exactly CMD_MEM_READ_LATENCY cycles after the grant.
REQ-024 SHALL, while flush[i]=1, clear bit i in every tag stage and mask rvalid[i] in that cycle; a same-cycle grant to core i is still issued but its tag bit is cleared.
REQ-025 SHALL sustain one grant per cycle back-to-back, with no bubble between consecutive grants.
REQ-026 SHALL assert paused=1 only in state PAUSED.
REQ-027 SHALL allow pause to rise in the same cycle as a grant; that grant is issued and drained.

Reset
REQ-028 SHALL, while reset=0, force state=RUN, rr=0, all tag stages=0, rvalid=0 and paused=0; gnt and mem_en are 0 because the state is held in reset.
REQ-029 SHALL discard all in-flight reads on reset mid-operation; no rvalid is produced for them after release.

Configuration
REQ-030 SHALL, with macro CMD_MEM_ARB_STATS_EN defined, add output conflict_cnt (16 bits), which increments each RUN cycle with two or more req bits set, saturates at 0xFFFF and resets to 0.
REQ-031 SHALL, with CMD_MEM_ARB_STATS_EN undefined, have neither the conflict_cnt port nor its logic.

Verification
REQ-032 SHALL cover a single requester: N_REQ=4, latency 3, req=0001, addr0=0x05 -> gnt=0001 and mem_addr=0x05 in the same cycle; rvalid=0001 3 cycles later with rdata=mem_rdata.
REQ-033 SHALL cover all-request fairness: req=1111 held 8 cycles, rr=0 -> grant order 0,1,2,3,0,1,2,3.
REQ-034 SHALL cover flush: grant to core 2, flush=0100 one cycle later -> no rvalid[2]; a simultaneous grant to core 1 still returns rvalid=0010 on time.
REQ-035 SHALL cover pause: pause raised with 2 reads in flight -> no new gnt; paused=1 after the last rvalid; pause dropped -> RUN and a grant in the next cycle.
REQ-036 SHALL cover reset mid-read: reset=0 for one cycle, 1 cycle after a grant -> no rvalid afterwards; rr=0.
REQ-037 SHALL cover the statistics counter: with CMD_MEM_ARB_STATS_EN, 5 cycles of req=0011 -> conflict_cnt=5; preload 0xFFFE plus 3 conflict cycles -> 0xFFFF.
